// File: rtl/multicycle_control_fsm_if.sv
// Control-unit bundle: instruction fields and status in, datapath enables and selects out.
// Latency: none, wires only.
// Backpressure: MemReady is the only stall input; the FSM holds its requests until it rises.
interface multicycle_control_fsm_if;
    logic [3:0] Opcode;
    logic [3:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       PCWrite;
    logic       PCSrc;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       MemToReg;
    logic       Illegal;
    logic [2:0] State;

    // Datapath / stimulus side: supplies IR fields and status, observes controls.
    modport master (
        output Opcode, Funct, Zero, MemReady,
        input  ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCSrc, IRWrite,
               MemRead, MemWrite, RegWrite, MemToReg, Illegal, State
    );

    // Control-unit side.
    modport slave (
        input  Opcode, Funct, Zero, MemReady,
        output ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCSrc, IRWrite,
               MemRead, MemWrite, RegWrite, MemToReg, Illegal, State
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM for the 16-bit CPU: FETCH/DECODE/EXEC/MEM/WB plus a sticky TRAP.
// Latency: BEQ 3, ALU/imm/SW 4, LW 5, MUL 3+MUL_CYCLES cycles; Moore outputs from state.
// Backpressure: FETCH and MEM hold their memory request until MemReady=1; MUL holds EXEC.
module multicycle_control_fsm #(
    parameter int MUL_CYCLES = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    multicycle_control_fsm_if.slave     bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_SLLI  = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1010;
    localparam logic [3:0] FN_MUL   = 4'b0010;

    // Counter holds the extra EXEC cycles after the first one.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_mul_cnt;
    logic [3:0] w_mul_cnt_next;
    logic       r_illegal;
    logic       w_illegal_next;
    logic       w_op_legal;
    logic       w_funct_legal;

    // Opcode and R-type function legality, consulted only in DECODE.
    always_comb begin
        w_op_legal    = 1'b0;
        w_funct_legal = 1'b0;
        case (bus.Opcode)
            OP_RTYPE, OP_ADDI, OP_SLLI, OP_LW, OP_SW, OP_BEQ: w_op_legal = 1'b1;
            default:                                          w_op_legal = 1'b0;
        endcase
        case (bus.Funct)
            4'b1111, 4'b1110, 4'b1101, 4'b0000,
            4'b0001, 4'b1100, 4'b0010: w_funct_legal = 1'b1;
            default:                   w_funct_legal = 1'b0;
        endcase
    end

    // State, MUL counter and sticky illegal flag; reset overrides any pending transition.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_FETCH;
            r_mul_cnt <= 4'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_mul_cnt <= w_mul_cnt_next;
            r_illegal <= w_illegal_next;
        end
    end

    // Next-state logic and Moore control outputs (MemReady/Zero gate only the listed strobes).
    always_comb begin
        w_next         = r_state;
        w_mul_cnt_next = r_mul_cnt;
        w_illegal_next = r_illegal;
        bus.ALUOp      = 2'b00;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.PCWrite    = 1'b0;
        bus.PCSrc      = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.MemToReg   = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC+2 is computed alongside the instruction read.
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.IRWrite = bus.MemReady;
                bus.PCWrite = bus.MemReady;
                if (bus.MemReady) w_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut.
                bus.ALUSrcB = 2'b11;
                if (!w_op_legal || (bus.Opcode == OP_RTYPE && !w_funct_legal)) begin
                    w_next         = S_TRAP;
                    w_illegal_next = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
                w_mul_cnt_next = (bus.Opcode == OP_RTYPE && bus.Funct == FN_MUL) ? MUL_LOAD : 4'd0;
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                case (bus.Opcode)
                    OP_RTYPE: begin
                        bus.ALUOp = 2'b10;
                        if (r_mul_cnt != 4'd0) w_mul_cnt_next = r_mul_cnt - 4'd1;
                        else                   w_next = S_WB;
                    end
                    OP_ADDI: begin
                        bus.ALUSrcB = 2'b01;
                        w_next      = S_WB;
                    end
                    OP_SLLI: begin
                        bus.ALUSrcB = 2'b01;
                        bus.ALUOp   = 2'b11;
                        w_next      = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        bus.ALUSrcB = 2'b01;
                        w_next      = S_MEM;
                    end
                    OP_BEQ: begin
                        bus.ALUOp   = 2'b01;
                        bus.PCSrc   = 1'b1;
                        bus.PCWrite = bus.Zero;
                        w_next      = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                // Request stays asserted until the memory accepts it.
                if (bus.Opcode == OP_LW) bus.MemRead  = 1'b1;
                else                     bus.MemWrite = 1'b1;
                if (bus.MemReady) w_next = (bus.Opcode == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = (bus.Opcode == OP_LW);
                w_next       = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    assign bus.State   = r_state;
    assign bus.Illegal = r_illegal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multi-cycle control FSM.
// Latency: each scenario walks the FSM cycle by cycle against a hand-written state trace.
// Backpressure: MemReady stalls are driven per cycle from small tables.
module tb_multicycle_control_fsm;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.MUL_CYCLES(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Structural invariants sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        n_vec++;
        if (bus.MemRead && bus.MemWrite) begin
            n_err++;
            $display("FAIL rd_wr_exclusive: MemRead=%0b MemWrite=%0b required not both 1", bus.MemRead, bus.MemWrite);
        end
        if (bus.PCWrite && bus.RegWrite) begin
            n_err++;
            $display("FAIL pcw_rw_exclusive: PCWrite=%0b RegWrite=%0b required not both 1", bus.PCWrite, bus.RegWrite);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.Opcode = 4'b0000; bus.Funct = 4'b0000; bus.Zero = 1'b0; bus.MemReady = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_vec++; if (bus.State !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", bus.State); end
        n_vec++; if (bus.MemRead !== 1'b1) begin n_err++; $display("FAIL rst_memread: got %0b want 1", bus.MemRead); end
        n_vec++; if (bus.ALUSrcB !== 2'b10) begin n_err++; $display("FAIL rst_alusrcb: got %0b want 10", bus.ALUSrcB); end
        n_vec++; if (bus.ALUSrcA !== 1'b0 || bus.ALUOp !== 2'b00) begin n_err++; $display("FAIL rst_alu: got srcA=%0b op=%0b want 0/00", bus.ALUSrcA, bus.ALUOp); end
        n_vec++; if (bus.IRWrite !== 1'b0 || bus.PCWrite !== 1'b0) begin n_err++; $display("FAIL rst_gated: got IRW=%0b PCW=%0b want 0/0", bus.IRWrite, bus.PCWrite); end
        n_vec++; if (bus.Illegal !== 1'b0 || bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0) begin n_err++; $display("FAIL rst_misc: got ill=%0b rw=%0b mw=%0b want 0", bus.Illegal, bus.RegWrite, bus.MemWrite); end
    endtask

    task automatic test_add();
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        int n_rw = 0;
        bus.Opcode = 4'b0000; bus.Funct = 4'b0000; bus.MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (bus.State !== exp_st[i]) begin n_err++; $display("FAIL add_state[%0d]: got %0d want %0d", i, bus.State, exp_st[i]); end
            if (i == 2) begin
                n_vec++; if (bus.ALUOp !== 2'b10 || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b00) begin n_err++; $display("FAIL add_exec: got op=%0b srcA=%0b srcB=%0b want 10/1/00", bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB); end
            end
            if (i == 3) begin
                n_vec++; if (bus.MemToReg !== 1'b0) begin n_err++; $display("FAIL add_memtoreg: got %0b want 0", bus.MemToReg); end
            end
            if (bus.RegWrite) n_rw++;
            tick();
        end
        #1;
        n_vec++; if (bus.State !== 3'd0) begin n_err++; $display("FAIL add_end: got %0d want 0", bus.State); end
        n_vec++; if (n_rw != 1) begin n_err++; $display("FAIL add_regwrite_cycles: got %0d want 1", n_rw); end
    endtask

    task automatic test_lw_stall();
        logic [2:0] exp_st [10] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        logic       mr     [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int n_irw = 0;
        bus.Opcode = 4'b1000; bus.Funct = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            bus.MemReady = mr[i];
            #1;
            n_vec++; if (bus.State !== exp_st[i]) begin n_err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.State, exp_st[i]); end
            if (exp_st[i] == 3'd0 || exp_st[i] == 3'd3) begin
                n_vec++; if (bus.MemRead !== 1'b1) begin n_err++; $display("FAIL lw_memread[%0d]: got %0b want 1", i, bus.MemRead); end
            end
            if (i == 9) begin
                n_vec++; if (bus.MemToReg !== 1'b1 || bus.RegWrite !== 1'b1) begin n_err++; $display("FAIL lw_wb: got m2r=%0b rw=%0b want 1/1", bus.MemToReg, bus.RegWrite); end
            end
            if (bus.IRWrite) n_irw++;
            tick();
        end
        bus.MemReady = 1'b1;
        #1;
        n_vec++; if (bus.State !== 3'd0) begin n_err++; $display("FAIL lw_end: got %0d want 0", bus.State); end
        n_vec++; if (n_irw != 1) begin n_err++; $display("FAIL lw_irwrite_pulses: got %0d want 1", n_irw); end
    endtask

    task automatic test_beq(input logic zero);
        logic [2:0] exp_st [3] = '{3'd0, 3'd1, 3'd2};
        bus.Opcode = 4'b1010; bus.Funct = 4'b0000; bus.MemReady = 1'b1; bus.Zero = zero;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (bus.State !== exp_st[i]) begin n_err++; $display("FAIL beq%0b_state[%0d]: got %0d want %0d", zero, i, bus.State, exp_st[i]); end
            if (i == 1) begin
                n_vec++; if (bus.ALUSrcB !== 2'b11 || bus.ALUSrcA !== 1'b0) begin n_err++; $display("FAIL beq%0b_decode: got srcB=%0b srcA=%0b want 11/0", zero, bus.ALUSrcB, bus.ALUSrcA); end
            end
            if (i == 2) begin
                n_vec++; if (bus.PCSrc !== 1'b1 || bus.ALUOp !== 2'b01) begin n_err++; $display("FAIL beq%0b_exec: got pcsrc=%0b op=%0b want 1/01", zero, bus.PCSrc, bus.ALUOp); end
                n_vec++; if (bus.PCWrite !== zero) begin n_err++; $display("FAIL beq%0b_pcwrite: got %0b want %0b", zero, bus.PCWrite, zero); end
            end
            tick();
        end
        #1;
        n_vec++; if (bus.State !== 3'd0) begin n_err++; $display("FAIL beq%0b_end: got %0d want 0", zero, bus.State); end
        bus.Zero = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0] exp_st [7] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd4};
        bus.Opcode = 4'b0000; bus.Funct = 4'b0010; bus.MemReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            n_vec++; if (bus.State !== exp_st[i]) begin n_err++; $display("FAIL mul_state[%0d]: got %0d want %0d", i, bus.State, exp_st[i]); end
            if (i >= 2 && i <= 5) begin
                n_vec++; if (bus.ALUOp !== 2'b10) begin n_err++; $display("FAIL mul_aluop[%0d]: got %0b want 10", i, bus.ALUOp); end
            end
            tick();
        end
        #1;
        n_vec++; if (bus.State !== 3'd0) begin n_err++; $display("FAIL mul_end: got %0d want 0", bus.State); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops    [3] = '{4'b1001, 4'b0100, 4'b0101};
        logic [1:0] exp_op [3] = '{2'b00, 2'b00, 2'b11};
        logic [2:0] last_st;
        bus.Funct = 4'b0000; bus.MemReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.Opcode = ops[k];
            last_st = (k == 0) ? 3'd3 : 3'd4;
            for (int i = 0; i < 4; i++) begin
                #1;
                n_vec++;
                if (bus.State !== ((i == 3) ? last_st : 3'(i))) begin n_err++; $display("FAIL b2b%0d_state[%0d]: got %0d want %0d", k, i, bus.State, (i == 3) ? last_st : 3'(i)); end
                if (i == 2) begin
                    n_vec++; if (bus.ALUOp !== exp_op[k] || bus.ALUSrcB !== 2'b01 || bus.ALUSrcA !== 1'b1) begin n_err++; $display("FAIL b2b%0d_exec: got op=%0b srcB=%0b srcA=%0b want %0b/01/1", k, bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA, exp_op[k]); end
                end
                if (i == 3 && k == 0) begin
                    n_vec++; if (bus.MemWrite !== 1'b1 || bus.MemRead !== 1'b0) begin n_err++; $display("FAIL b2b_sw_mem: got mw=%0b mr=%0b want 1/0", bus.MemWrite, bus.MemRead); end
                end
                if (i == 3 && k != 0) begin
                    n_vec++; if (bus.RegWrite !== 1'b1 || bus.MemToReg !== 1'b0) begin n_err++; $display("FAIL b2b%0d_wb: got rw=%0b m2r=%0b want 1/0", k, bus.RegWrite, bus.MemToReg); end
                end
                tick();
            end
        end
        #1;
        n_vec++; if (bus.State !== 3'd0) begin n_err++; $display("FAIL b2b_end: got %0d want 0", bus.State); end
    endtask

    task automatic test_illegal(input logic [3:0] op, input logic [3:0] fn);
        logic [2:0] exp_st [3] = '{3'd0, 3'd1, 3'd7};
        bus.Opcode = op; bus.Funct = fn; bus.MemReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_vec++;
            if (bus.State !== ((i < 3) ? exp_st[i] : 3'd7)) begin n_err++; $display("FAIL ill_%0h%0h_state[%0d]: got %0d want %0d", op, fn, i, bus.State, (i < 3) ? exp_st[i] : 3'd7); end
            if (i >= 2) begin
                n_vec++;
                if (bus.Illegal !== 1'b1 || bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0 || bus.PCWrite !== 1'b0 ||
                    bus.IRWrite !== 1'b0 || bus.RegWrite !== 1'b0) begin
                    n_err++;
                    $display("FAIL ill_%0h%0h_trap[%0d]: got ill=%0b mr=%0b mw=%0b pcw=%0b irw=%0b rw=%0b want 1/0/0/0/0/0",
                             op, fn, i, bus.Illegal, bus.MemRead, bus.MemWrite, bus.PCWrite, bus.IRWrite, bus.RegWrite);
                end
                // Opcode is don't-care in TRAP; wiggle it to prove it is ignored.
                bus.Opcode = 4'b0000; bus.Funct = 4'b0000;
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_vec++; if (bus.State !== 3'd0 || bus.Illegal !== 1'b0) begin n_err++; $display("FAIL ill_%0h%0h_reset: got state=%0d ill=%0b want 0/0", op, fn, bus.State, bus.Illegal); end
    endtask

    task automatic test_reset_midflight();
        // SW stalled in MEM, reset with MemReady pending.
        bus.Opcode = 4'b1001; bus.Funct = 4'b0000; bus.MemReady = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.MemReady = 1'b0;
        #1;
        n_vec++; if (bus.State !== 3'd3 || bus.MemWrite !== 1'b1) begin n_err++; $display("FAIL rmid_sw_mem: got state=%0d mw=%0b want 3/1", bus.State, bus.MemWrite); end
        tick();
        rst = 1'b1; bus.MemReady = 1'b1;
        tick();
        rst = 1'b0; bus.MemReady = 1'b0;
        #1;
        n_vec++; if (bus.State !== 3'd0 || bus.MemWrite !== 1'b0 || bus.RegWrite !== 1'b0) begin n_err++; $display("FAIL rmid_sw_reset: got state=%0d mw=%0b rw=%0b want 0/0/0", bus.State, bus.MemWrite, bus.RegWrite); end
        // MUL reset during its second EXEC cycle.
        bus.Opcode = 4'b0000; bus.Funct = 4'b0010; bus.MemReady = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #1;
        n_vec++; if (bus.State !== 3'd2) begin n_err++; $display("FAIL rmid_mul_exec: got %0d want 2", bus.State); end
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.MemReady = 1'b0;
        #1;
        n_vec++; if (bus.State !== 3'd0 || bus.RegWrite !== 1'b0) begin n_err++; $display("FAIL rmid_mul_reset: got state=%0d rw=%0b want 0/0", bus.State, bus.RegWrite); end
        tick();
        #1;
        n_vec++; if (bus.State !== 3'd0 || bus.RegWrite !== 1'b0) begin n_err++; $display("FAIL rmid_mul_hold: got state=%0d rw=%0b want 0/0", bus.State, bus.RegWrite); end
        bus.MemReady = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_beq(1'b1);
        test_beq(1'b0);
        test_mul();
        test_back_to_back();
        test_illegal(4'b1111, 4'b0000);
        test_illegal(4'b0000, 4'b0101);
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main multi-cycle control unit for the 16-bit CPU. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives the datapath enables and mux selects. It issues the 2-bit ALUOp that the ALU-control decoder consumes. It stalls on a memory ready handshake and on a fixed-latency multiplier.

Parameters:
MUL_CYCLES, 4, number of EXEC cycles held for R-type MUL (Funct 0010); legal range 1..15.

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Opcode  in  4  IR[15:12]; only read in DECODE and later states
Funct  in  4  IR[3:0]; function field for R-type
Zero  in  1  ALU zero flag
MemReady  in  1  memory completes the current access this cycle
ALUOp  out  2  00 add, 01 sub (BEQ), 10 use Funct, 11 shift-left (SLLI)
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 = register B, 01 = sign-extended imm, 10 = constant 2, 11 = branch offset << 1
PCWrite  out  1  PC load enable
PCSrc  out  1  0 = ALU result (PC+2), 1 = ALUOut (branch target)
IRWrite  out  1  instruction register load
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
RegWrite  out  1  register file write
MemToReg  out  1  1 = write-back data comes from memory
Illegal  out  1  sticky illegal-instruction flag
State  out  3  current state code (debug)

Behaviour:
- Opcodes: 0000 R-type, 0100 ADDI, 0101 SLLI, 1000 LW, 1001 SW, 1010 BEQ; any other opcode is illegal.
- Legal R-type Funct values: 1111, 1110, 1101, 0000, 0001, 1100, 0010. Any other Funct value is illegal.
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Outputs are Moore, decoded from state, except for the MemReady-gated and Zero-gated strobes noted below.
- Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, ALUSrcA=0, ALUSrcB=10, ALUOp=00.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; moves to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target).
  - Illegal opcode or illegal Funct -> TRAP; otherwise -> EXEC.
  - Loads the mul counter with MUL_CYCLES-1 when Funct=0010 for R-type; otherwise loads 0.
- EXEC:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Stays in EXEC while counter≠0, decrementing each cycle. -> WB when counter=0.
  - ADDI: ALUSrcA=1, ALUSrcB=01, ALUOp=00 -> WB.
  - SLLI: ALUSrcA=1, ALUSrcB=01, ALUOp=11 -> WB.
  - LW/SW: ALUSrcA=1, ALUSrcB=01, ALUOp=00 -> MEM.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=Zero -> FETCH.
- MEM:
  - LW asserts MemRead=1; SW asserts MemWrite=1.
  - The request is held steady until MemReady=1.
  - On MemReady=1: LW -> WB, SW -> FETCH.
- WB:
  - RegWrite=1; MemToReg=1 only for LW.
  - -> FETCH.
- TRAP:
  - All enables and requests are 0; Illegal=1.
  - Stays in TRAP until Reset.
- Reset:
  - At the clock edge with Reset=1: state -> FETCH, counter -> 0, Illegal -> 0.
  - Outputs then show FETCH values (MemRead=1, ALUSrcB=10, all other outputs 0 unless gated by MemReady).
  - Reset takes priority over every transition, including a pending MemReady in MEM or a mid-count MUL.
- Latency (cycles, MemReady always 1):
  - BEQ 3, ADD/ADDI/SLLI 4, SW 4, LW 5.
  - MUL 3+MUL_CYCLES.
  - Each cycle with MemReady=0 adds one cycle.
- Inputs Opcode, Funct and Zero are don't-care in FETCH and TRAP.
- Exactly one of MemRead and MemWrite may be high in any cycle.
- PCWrite is never asserted together with RegWrite.

Test Plan:
- Reset, then ADD (Opcode 0000, Funct 0000), MemReady=1 -> State sequence 0,1,2,4,0. ALUOp=10 in EXEC; RegWrite=1 for exactly one cycle; MemToReg=0.
- LW (1000) with MemReady low for 2 cycles in FETCH and 3 in MEM -> 10 cycles total. MemRead is held high throughout both stalls. IRWrite pulses once. WB has MemToReg=1.
- BEQ (1010) with Zero=1, then again with Zero=0 -> State 0,1,2,0 both times. PCSrc=1 and ALUOp=01 in EXEC. PCWrite=1 in EXEC only when Zero=1.
- MUL (Funct 0010) with MUL_CYCLES=4 -> EXEC held exactly 4 cycles with ALUOp=10, then WB. 7 cycles total.
- Opcode 1111, then R-type with Funct 0101 -> each reaches TRAP (State=7) after DECODE. Illegal=1 with all enables 0 until Reset; after Reset, State=0 and Illegal=0.
- Reset asserted in MEM during SW with MemReady=0, and separately mid-MUL count -> next state FETCH. MemWrite=0, no RegWrite pulse.
